ssd1306_display: RTL and testbench



---
 rtl/ssd1306_display.sv | 217 +++++++++++++++++++++
 tb/tb_ssd1306_display.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_display.sv
// SSD1306 128x64 OLED emulation: SPI command/data parser, 1 KiB framebuffer and
// a 640x480@60 scanout with integer pixel replication, centred in the active area.
module ssd1306_display #(
    parameter int H_OFFSET   = 64,
    parameter int V_OFFSET   = 112,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       clk_25m,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_dc,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       pixelValue
);

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int HS_START = 656;
    localparam int HS_END   = 751;
    localparam int VS_START = 490;
    localparam int VS_END   = 491;
    localparam int WIN_W    = 128 << SCALE_LOG2;
    localparam int WIN_H    = 64 << SCALE_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        COL_S,
        COL_E,
        PAGE_S,
        PAGE_E,
        SKIP1
    } parse_state_t;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_25m) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: window test and framebuffer address
    // ------------------------------------------------------------------
    logic [9:0] h_rel;
    logic [9:0] v_rel;
    logic [6:0] x0;
    logic [5:0] y0;
    logic       window0;
    logic [9:0] rd_addr;
    logic       hsync0;
    logic       vsync0;
    logic       hblank0;
    logic       vblank0;

    // Left of / above the image the subtraction wraps to a large value, so a
    // single unsigned compare covers both window edges.
    assign h_rel   = h_cnt - 10'(H_OFFSET);
    assign v_rel   = v_cnt - 10'(V_OFFSET);
    assign window0 = (h_rel < 10'(WIN_W)) && (v_rel < 10'(WIN_H));
    assign x0      = 7'(h_rel >> SCALE_LOG2);
    assign y0      = 6'(v_rel >> SCALE_LOG2);
    assign rd_addr = {y0[5:3], x0};

    assign hsync0  = (h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END));
    assign vsync0  = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));
    assign hblank0 = (h_cnt >= 10'(H_ACTIVE));
    assign vblank0 = (v_cnt >= 10'(V_ACTIVE));

    // ------------------------------------------------------------------
    // Framebuffer: byte address = page*128 + column, bit = row within page
    // ------------------------------------------------------------------
    logic [7:0] fb [0:1023];
    logic [7:0] rd_data;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [6:0] col_ptr;
    logic [2:0] page_ptr;

    assign wr_en   = byte_valid & byte_dc;
    assign wr_addr = {page_ptr, col_ptr};

    // NOTE: the framebuffer has no reset so it maps onto block RAM; image survives reset.
    always_ff @(posedge clk_25m) begin
        if (wr_en) begin
            fb[wr_addr] <= byte_data;
        end
        rd_data <= fb[rd_addr];
    end

    // ------------------------------------------------------------------
    // Stage 1 / stage 2: align timing with RAM data, then form the pixel
    // ------------------------------------------------------------------
    logic       window1;
    logic [2:0] ybit1;
    logic       hsync1;
    logic       vsync1;
    logic       hblank1;
    logic       vblank1;
    logic       display_on;
    logic       invert;

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            window1    <= 1'b0;
            ybit1      <= '0;
            hsync1     <= 1'b0;
            vsync1     <= 1'b0;
            hblank1    <= 1'b0;
            vblank1    <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            hblank     <= 1'b0;
            vblank     <= 1'b0;
            pixelValue <= 1'b0;
        end else begin
            window1    <= window0;
            ybit1      <= y0[2:0];
            hsync1     <= hsync0;
            vsync1     <= vsync0;
            hblank1    <= hblank0;
            vblank1    <= vblank0;
            hsync      <= hsync1;
            vsync      <= vsync1;
            hblank     <= hblank1;
            vblank     <= vblank1;
            pixelValue <= window1 & display_on & (rd_data[ybit1] ^ invert);
        end
    end

    // ------------------------------------------------------------------
    // Byte parser: data bytes walk the column/page window, commands drive the FSM
    // ------------------------------------------------------------------
    parse_state_t state;
    logic [6:0]   col_start;
    logic [6:0]   col_end;
    logic [2:0]   page_start;
    logic [2:0]   page_end;

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            state      <= IDLE;
            col_ptr    <= '0;
            col_start  <= '0;
            col_end    <= 7'd127;
            page_ptr   <= '0;
            page_start <= '0;
            page_end   <= 3'd7;
            display_on <= 1'b0;
            invert     <= 1'b0;
        end else if (byte_valid) begin
            if (byte_dc) begin
                // Data never touches parser state, so it may interleave with arguments.
                if (col_ptr == col_end) begin
                    col_ptr  <= col_start;
                    page_ptr <= (page_ptr == page_end) ? page_start : page_ptr + 3'd1;
                end else begin
                    col_ptr <= col_ptr + 7'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        case (byte_data)
                            8'hAE: display_on <= 1'b0;
                            8'hAF: display_on <= 1'b1;
                            8'hA6: invert     <= 1'b0;
                            8'hA7: invert     <= 1'b1;
                            8'h21: state      <= COL_S;
                            8'h22: state      <= PAGE_S;
                            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                            8'hD5, 8'hD9, 8'hDA, 8'hDB: state <= SKIP1;
                            default: state <= IDLE;
                        endcase
                    end
                    COL_S: begin
                        col_start <= byte_data[6:0];
                        col_ptr   <= byte_data[6:0];
                        state     <= COL_E;
                    end
                    COL_E: begin
                        col_end <= byte_data[6:0];
                        state   <= IDLE;
                    end
                    PAGE_S: begin
                        page_start <= byte_data[2:0];
                        page_ptr   <= byte_data[2:0];
                        state      <= PAGE_E;
                    end
                    PAGE_E: begin
                        page_end <= byte_data[2:0];
                        state    <= IDLE;
                    end
                    SKIP1:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_display.sv
// Directed bench for ssd1306_display; V_OFFSET is set to 0 so the image starts on
// line 0 and every scenario fits in a few dozen scan lines.
module tb_ssd1306_display;

    localparam int LINE = 800;

    logic       clk_25m    = 1'b0;
    logic       reset      = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       byte_dc    = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       pixelValue;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #20 clk_25m = ~clk_25m;

    // Cycles since reset release: equals the raster position h + 800*v.
    always @(posedge clk_25m) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    ssd1306_display #(
        .H_OFFSET  (64),
        .V_OFFSET  (0),
        .SCALE_LOG2(2)
    ) dut (
        .clk_25m   (clk_25m),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblank    (hblank),
        .vblank    (vblank),
        .pixelValue(pixelValue)
    );

    // {hsync, vsync, hblank, vblank} for raster position p (negative: pipeline still reset)
    function automatic logic [3:0] exp_sync(input int p);
        int hx;
        int vy;
        if (p < 0) return 4'b0000;
        hx = p % LINE;
        vy = (p / LINE) % 525;
        return {(hx >= 656 && hx <= 751), (vy == 490 || vy == 491), (hx >= 640), (vy >= 480)};
    endfunction

    task automatic send_byte(input logic dc, input logic [7:0] b);
        byte_valid = 1'b1;
        byte_dc    = dc;
        byte_data  = b;
        @(negedge clk_25m);
        byte_valid = 1'b0;
        byte_dc    = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    task automatic do_reset();
        @(negedge clk_25m);
        reset = 1'b1;
        repeat (2) @(negedge clk_25m);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p;
        int hs_cnt;
        int shown;
        logic [4:0] obs;
        logic [4:0] exp_v;
        repeat (3) @(negedge clk_25m);
        obs = {hsync, vsync, hblank, vblank, pixelValue};
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000", obs);
        end
        reset  = 1'b0;
        hs_cnt = 0;
        shown  = 0;
        while (cyc < 2 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL reset_scan p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
            if (p >= 0 && hsync === 1'b1) hs_cnt++;
            if (p >= 0 && (p % LINE) == LINE - 1) begin
                checks++;
                if (hs_cnt !== 96) begin
                    errors++;
                    $display("FAIL hsync_width line=%0d got=%0d want=96", p / LINE, hs_cnt);
                end
                hs_cnt = 0;
            end
        end
    endtask

    // Fill all 1024 bytes with zero; the default window wraps the pointer to (0,0).
    task automatic test_clear();
        for (int i = 0; i < 1024; i++) send_data(8'h00);
    endtask

    task automatic test_invert();
        int p;
        int hx;
        int vy;
        int shown;
        logic [4:0] obs;
        logic [4:0] exp_v;
        do_reset();
        send_cmd(8'hAF);
        send_cmd(8'hA7);
        shown = 0;
        while (cyc < 4 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            hx    = p % LINE;
            vy    = p / LINE;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), (p >= 0 && hx >= 64 && hx <= 575 && vy <= 255)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL invert p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
    endtask

    task automatic test_single_pixel();
        int p;
        int hx;
        int vy;
        int shown;
        logic [4:0] obs;
        logic [4:0] exp_v;
        do_reset();
        send_cmd(8'hAF);
        send_data(8'h01);
        shown = 0;
        while (cyc < 4 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            hx    = p % LINE;
            vy    = p / LINE;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), (p >= 0 && vy < 4 && hx >= 64 && hx <= 67)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL single_pixel p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
    endtask

    // Columns 10..11, pages 1..2: writes land at (1,10),(1,11),(2,10),(2,11),(1,10).
    task automatic test_write_window();
        int p;
        int hx;
        int vy;
        int shown;
        logic lit;
        logic [4:0] obs;
        logic [4:0] exp_v;
        send_cmd(8'h21); send_cmd(8'd10); send_cmd(8'd11);
        send_cmd(8'h22); send_cmd(8'd1);  send_cmd(8'd2);
        send_data(8'h80); send_data(8'h80); send_data(8'h01); send_data(8'h01); send_data(8'h40);
        shown = 0;
        while (cyc < 68 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            hx    = p % LINE;
            vy    = p / LINE;
            lit   = (vy < 4 && hx >= 64 && hx <= 67) ||
                    (vy >= 56 && vy <= 59 && hx >= 104 && hx <= 107) ||
                    (vy >= 60 && vy <= 63 && hx >= 108 && hx <= 111) ||
                    (vy >= 64 && vy <= 67 && hx >= 104 && hx <= 111);
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), lit};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL write_window p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
    endtask

    task automatic test_skip_arg();
        int p;
        int hx;
        int vy;
        int shown;
        logic [4:0] obs;
        logic [4:0] exp_v;
        do_reset();
        send_cmd(8'h81);
        send_cmd(8'hAF);
        shown = 0;
        while (cyc < LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL skip_arg_off p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
        send_cmd(8'hAF);
        while (cyc < 4 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            hx    = p % LINE;
            vy    = p / LINE;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), (vy < 4 && hx >= 64 && hx <= 67)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL skip_arg_on p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
    endtask

    task automatic test_reset_mid_cmd();
        int p;
        int hx;
        int vy;
        int shown;
        logic [4:0] obs;
        logic [4:0] exp_v;
        do_reset();
        send_cmd(8'h22);
        do_reset();
        send_cmd(8'hAF);
        send_data(8'h03);
        shown = 0;
        while (cyc < 8 * LINE + 2) begin
            @(negedge clk_25m);
            p     = cyc - 2;
            hx    = p % LINE;
            vy    = p / LINE;
            obs   = {hsync, vsync, hblank, vblank, pixelValue};
            exp_v = {exp_sync(p), (p >= 0 && vy < 8 && hx >= 64 && hx <= 67)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (shown < 8) $display("FAIL reset_mid_cmd p=%0d got=%b want=%b", p, obs, exp_v);
                shown++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_invert();
        test_single_pixel();
        test_write_window();
        test_skip_arg();
        test_reset_mid_cmd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
